// File: rtl/piso_tx_pkg.sv
// Shared definitions for the serial transmit/receive pair: the two-state framing
// encoding and the bit-counter width helper.
package piso_tx_pkg;

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_SHIFT = 1'b1;

    typedef enum logic {
        S_IDLE  = ST_IDLE,
        S_SHIFT = ST_SHIFT
    } state_t;

    // Counter wide enough to index N bits; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/piso_tx.sv
// Parallel-in/serial-out transmitter with a one-word holding slot for gapless frames.
// First bit 1 cycle after accept; din_ready drops only while the holding slot is full.
module piso_tx
    import piso_tx_pkg::*;
#(
    parameter int N         = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] din,
    input  logic         din_valid,
    output logic         din_ready,
    output logic         dout,
    output logic         dout_en,
    output logic         frame_start,
    output logic         frame_done,
    output logic         busy
);

    localparam int              CW       = cnt_width(N);
    localparam logic [CW-1:0]   CNT_LAST = CW'(N - 1);

    state_t          state_q, state_d;
    logic [N-1:0]    sr_q, sr_d;
    logic [N-1:0]    hold_q, hold_d;
    logic            hold_vld_q, hold_vld_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic            accept;
    logic            shifting;
    logic [N-1:0]    sr_shifted;

    assign shifting = (state_q == S_SHIFT);
    assign accept   = din_valid & ~hold_vld_q;

    // Zero-fill from the far end so an emptied shifter reads as all-zero.
    assign sr_shifted = MSB_FIRST ? {sr_q[N-2:0], 1'b0} : {1'b0, sr_q[N-1:1]};

    always_comb begin
        state_d    = state_q;
        sr_d       = sr_q;
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q;
        cnt_d      = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    sr_d    = din;
                    cnt_d   = '0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                sr_d  = sr_shifted;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    // Held word wins over a fresh one so ordering is preserved.
                    cnt_d = '0;
                    if (hold_vld_q) begin
                        sr_d       = hold_q;
                        hold_vld_d = 1'b0;
                    end else if (accept) begin
                        sr_d = din;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (accept) begin
                    hold_d     = din;
                    hold_vld_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            sr_q       <= '0;
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
            cnt_q      <= cnt_d;
        end
    end

    assign din_ready   = ~hold_vld_q;
    assign dout_en     = shifting;
    assign dout        = shifting & (MSB_FIRST ? sr_q[N-1] : sr_q[0]);
    assign frame_start = shifting & (cnt_q == '0);
    assign frame_done  = shifting & (cnt_q == CNT_LAST);
    assign busy        = shifting | hold_vld_q;

endmodule
